ika9958_st_prog: RTL and testbench

- Programmable, parametrised video timing generator. Successor to the fixed-PLA screen-timing block: the same counter, field and sync structure, but line and frame geometry come from input registers instead of hard-wired comparators.
- Adds programmable totals, sync, blank and adjust values, plus interlace half-line placement and N generic horizontal/vertical match windows.
- Sits beside the register file and drives the sync pins and the downstream fetch/render sequencers.

---
 rtl/ika9958_st_prog.sv | 211 +++++++++++++++++++++
 tb/tb_ika9958_st_prog.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika9958_st_prog.sv
// ----------------------------------------------------------------------------
// ika9958_st_prog -- programmable video timing generator.
//
// A horizontal/vertical counter pair with field tracking. Line and frame
// geometry, sync, blank, adjust and match windows are all taken from input
// registers and compared live (no shadowing). Every output is registered and
// describes the counter state of the previous enabled cycle; o_hcnt/o_vcnt
// are delayed by the same cycle so they line up with the pins.
//
// Optional feature (macro IKA9958_ST_EXTLOCK_EN):
//   external HRST/VRST lock through enable-gated synchronizers. When the
//   macro is undefined, i_HRST_n and i_VRST_n are ignored.
//
// Ports:
//   phiA, RST_async_n        master clock, asynchronous active-low reset
//   i_phiL_NCEN              clock enable; all state advances only when high
//   i_hlast / i_vlast        last hcnt value / last vcnt value of field 0
//   i_hsync_end              hsync while hcnt < i_hsync_end
//   i_hblk_start/_end        hblank when hcnt >= start or hcnt < end
//   i_vsync_start/_end       vsync lines [start, end)
//   i_vblk_start/_end        vblank, same wrap rule as horizontal
//   i_il                     interlace enable
//   i_hadj / i_vadj          4-bit signed adjust values
//   i_win_h0/h1, i_win_v0/v1 per-window ranges [h0,h1) x [v0,v1)
//   i_HRST_n / i_VRST_n      external lock inputs (asynchronous)
//   o_hcnt/o_vcnt/o_field    counter state aligned with the pins
//   o_HSYNC_n/o_CSYNC_n/o_BLK_n  video pins
//   o_hadj_cnt/o_vadj_cnt    counters plus sign-extended adjust, wrapping
//   o_line_tick/o_frame_tick start-of-line / start-of-frame pulses
//   o_win                    per-window in-range flags
// ----------------------------------------------------------------------------
module ika9958_st_prog #(
    parameter int HW        = 9,
    parameter int VW        = 9,
    parameter int NUM_WIN   = 2,
    parameter int HRST_LINE = 6
) (
    input  logic                  phiA,
    input  logic                  RST_async_n,
    input  logic                  i_phiL_NCEN,
    input  logic [HW-1:0]         i_hlast,
    input  logic [HW-1:0]         i_hsync_end,
    input  logic [HW-1:0]         i_hblk_start,
    input  logic [HW-1:0]         i_hblk_end,
    input  logic [VW-1:0]         i_vlast,
    input  logic [VW-1:0]         i_vsync_start,
    input  logic [VW-1:0]         i_vsync_end,
    input  logic [VW-1:0]         i_vblk_start,
    input  logic [VW-1:0]         i_vblk_end,
    input  logic                  i_il,
    input  logic [3:0]            i_hadj,
    input  logic [3:0]            i_vadj,
    input  logic [NUM_WIN*HW-1:0] i_win_h0,
    input  logic [NUM_WIN*HW-1:0] i_win_h1,
    input  logic [NUM_WIN*VW-1:0] i_win_v0,
    input  logic [NUM_WIN*VW-1:0] i_win_v1,
    input  logic                  i_HRST_n,
    input  logic                  i_VRST_n,
    output logic [HW-1:0]         o_hcnt,
    output logic [VW-1:0]         o_vcnt,
    output logic                  o_field,
    output logic                  o_HSYNC_n,
    output logic                  o_CSYNC_n,
    output logic                  o_BLK_n,
    output logic [HW-1:0]         o_hadj_cnt,
    output logic [VW-1:0]         o_vadj_cnt,
    output logic                  o_line_tick,
    output logic                  o_frame_tick,
    output logic [NUM_WIN-1:0]    o_win
);

    localparam logic [VW-1:0] HRST_V = VW'(HRST_LINE);

    logic [HW-1:0]      hcnt;
    logic [VW-1:0]      vcnt;
    logic               field;

    logic               line_end;
    logic               frame_end;
    logic [VW-1:0]      vend;
    logic               hrst_line;
    logic               hrst_edge;
    logic               vrst_lock;

    logic [HW-1:0]      half;
    logic               half_mode;
    logic               after_start;
    logic               before_end;
    logic               hsync;
    logic               vsync;
    logic               hblk;
    logic               vblk;
    logic [NUM_WIN-1:0] win_next;

    assign line_end  = (hcnt == i_hlast);
    // Field 1 of an interlaced frame carries one extra line.
    assign vend      = i_vlast + {{(VW-1){1'b0}}, i_il & field};
    assign frame_end = (vcnt == vend);
    assign hrst_line = (vcnt == HRST_V);

`ifdef IKA9958_ST_EXTLOCK_EN
    logic [1:0] hrst_sync;
    logic       hrst_prev;
    logic [2:0] vrst_sync;
    logic       vrst_all_prev;
    logic       vrst_all;

    assign vrst_all  = (vrst_sync == 3'b000);
    // Falling edge on the synchronized HRST, honoured on one line only.
    assign hrst_edge = hrst_prev & ~hrst_sync[1] & hrst_line;
    // VRST fires once on entry into the all-asserted state.
    assign vrst_lock = vrst_all & ~vrst_all_prev;

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            hrst_sync     <= '0;
            hrst_prev     <= 1'b0;
            vrst_sync     <= '0;
            vrst_all_prev <= 1'b0;
        end else if (i_phiL_NCEN) begin
            hrst_sync     <= {hrst_sync[0], i_HRST_n};
            hrst_prev     <= hrst_sync[1];
            vrst_sync     <= {vrst_sync[1:0], i_VRST_n};
            vrst_all_prev <= vrst_all;
        end
    end
`else
    logic unused_lock;

    assign hrst_edge   = 1'b0;
    assign vrst_lock   = 1'b0;
    assign unused_lock = i_HRST_n ^ i_VRST_n ^ hrst_line;
`endif

    // Counters. hcnt+1 wraps naturally at 2^HW, so a lowered i_hlast can
    // never lock the counter up.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            hcnt  <= '0;
            vcnt  <= '0;
            field <= 1'b0;
        end else if (i_phiL_NCEN) begin
            hcnt <= (line_end || hrst_edge) ? '0 : hcnt + 1'b1;
            if (vrst_lock) begin
                vcnt  <= '0;
                field <= 1'b0;
            end else if (line_end) begin
                if (frame_end) begin
                    vcnt  <= '0;
                    field <= i_il & ~field;
                end else begin
                    vcnt <= vcnt + 1'b1;
                end
            end
        end
    end

    // Decode of the current counter state.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        half        = i_hlast >> 1;
        half_mode   = i_il & field;
        hsync       = (hcnt < i_hsync_end);
        hblk        = (hcnt >= i_hblk_start) | (hcnt < i_hblk_end);
        vblk        = (vcnt >= i_vblk_start) | (vcnt < i_vblk_end);
        // In interlaced field 1 both vsync transitions move to mid-line.
        after_start = (vcnt > i_vsync_start) |
                      ((vcnt == i_vsync_start) & (~half_mode | (hcnt >= half)));
        before_end  = (vcnt < i_vsync_end) |
                      ((vcnt == i_vsync_end) & half_mode & (hcnt < half));
        vsync       = after_start & before_end;
        win_next    = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            win_next[i] = (hcnt >= i_win_h0[i*HW +: HW]) & (hcnt < i_win_h1[i*HW +: HW]) &
                          (vcnt >= i_win_v0[i*VW +: VW]) & (vcnt < i_win_v1[i*VW +: VW]);
        end
    end

    // Registered outputs, one enabled cycle behind the counters.
    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            o_hcnt       <= '0;
            o_vcnt       <= '0;
            o_field      <= 1'b0;
            o_HSYNC_n    <= 1'b1;
            o_CSYNC_n    <= 1'b1;
            o_BLK_n      <= 1'b0;
            o_hadj_cnt   <= '0;
            o_vadj_cnt   <= '0;
            o_line_tick  <= 1'b0;
            o_frame_tick <= 1'b0;
            o_win        <= '0;
        end else if (i_phiL_NCEN) begin
            o_hcnt       <= hcnt;
            o_vcnt       <= vcnt;
            o_field      <= field;
            o_HSYNC_n    <= ~hsync;
            o_CSYNC_n    <= ~(hsync ^ vsync);
            o_BLK_n      <= ~(hblk | vblk);
            o_hadj_cnt   <= hcnt + {{(HW-4){i_hadj[3]}}, i_hadj};
            o_vadj_cnt   <= vcnt + {{(VW-4){i_vadj[3]}}, i_vadj};
            o_line_tick  <= (hcnt == '0);
            o_frame_tick <= (hcnt == '0) && (vcnt == '0);
            o_win        <= win_next;
        end
    end

endmodule

// File: tb/tb_ika9958_st_prog.sv
module tb_ika9958_st_prog;

    localparam int HW = 9;
    localparam int VW = 9;
    localparam int NW = 2;

    logic phiA = 1'b0;
    logic RST_async_n = 1'b1;
    logic i_phiL_NCEN = 1'b1;
    logic [HW-1:0] i_hlast, i_hsync_end, i_hblk_start, i_hblk_end;
    logic [VW-1:0] i_vlast, i_vsync_start, i_vsync_end, i_vblk_start, i_vblk_end;
    logic i_il;
    logic [3:0] i_hadj, i_vadj;
    logic [NW*HW-1:0] i_win_h0, i_win_h1;
    logic [NW*VW-1:0] i_win_v0, i_win_v1;
    logic i_HRST_n = 1'b1;
    logic i_VRST_n = 1'b1;
    logic [HW-1:0] o_hcnt, o_hadj_cnt;
    logic [VW-1:0] o_vcnt, o_vadj_cnt;
    logic o_field, o_HSYNC_n, o_CSYNC_n, o_BLK_n, o_line_tick, o_frame_tick;
    logic [NW-1:0] o_win;

    int n_cmp = 0;
    int n_fail = 0;
    int k = 0;   // enabled edges since reset release

    always #5 phiA = ~phiA;

    ika9958_st_prog #(.HW(HW), .VW(VW), .NUM_WIN(NW), .HRST_LINE(6)) dut (
        .phiA(phiA), .RST_async_n(RST_async_n), .i_phiL_NCEN(i_phiL_NCEN),
        .i_hlast(i_hlast), .i_hsync_end(i_hsync_end),
        .i_hblk_start(i_hblk_start), .i_hblk_end(i_hblk_end),
        .i_vlast(i_vlast), .i_vsync_start(i_vsync_start), .i_vsync_end(i_vsync_end),
        .i_vblk_start(i_vblk_start), .i_vblk_end(i_vblk_end),
        .i_il(i_il), .i_hadj(i_hadj), .i_vadj(i_vadj),
        .i_win_h0(i_win_h0), .i_win_h1(i_win_h1), .i_win_v0(i_win_v0), .i_win_v1(i_win_v1),
        .i_HRST_n(i_HRST_n), .i_VRST_n(i_VRST_n),
        .o_hcnt(o_hcnt), .o_vcnt(o_vcnt), .o_field(o_field),
        .o_HSYNC_n(o_HSYNC_n), .o_CSYNC_n(o_CSYNC_n), .o_BLK_n(o_BLK_n),
        .o_hadj_cnt(o_hadj_cnt), .o_vadj_cnt(o_vadj_cnt),
        .o_line_tick(o_line_tick), .o_frame_tick(o_frame_tick), .o_win(o_win)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: position inside the frame derived from the number of
    // enabled cycles, then every output evaluated from its defining rule.
    task automatic check_model();
        int L, F0, F1, P, r, fld, ln, h, p, off, sa, sv;
        bit hs, vs, hb, vb;
        logic [NW-1:0] w;
        if (k == 0) begin
            check("rst_hcnt", 32'(o_hcnt), 0);
            check("rst_vcnt", 32'(o_vcnt), 0);
            check("rst_field", 32'(o_field), 0);
            check("rst_hsync_n", 32'(o_HSYNC_n), 1);
            check("rst_csync_n", 32'(o_CSYNC_n), 1);
            check("rst_blk_n", 32'(o_BLK_n), 0);
            check("rst_hadj", 32'(o_hadj_cnt), 0);
            check("rst_vadj", 32'(o_vadj_cnt), 0);
            check("rst_line_tick", 32'(o_line_tick), 0);
            check("rst_frame_tick", 32'(o_frame_tick), 0);
            check("rst_win", 32'(o_win), 0);
            return;
        end
        L  = int'(i_hlast) + 1;
        F0 = int'(i_vlast) + 1;
        F1 = i_il ? int'(i_vlast) + 2 : 0;
        P  = L * (F0 + F1);
        r  = (k - 1) % P;
        fld = 0;
        if (r >= L * F0) begin
            fld = 1;
            r -= L * F0;
        end
        ln  = r / L;
        h   = r % L;
        p   = ln * L + h;
        off = (fld == 1 && i_il) ? int'(i_hlast) / 2 : 0;
        hs  = h < int'(i_hsync_end);
        vs  = (p >= int'(i_vsync_start) * L + off) && (p < int'(i_vsync_end) * L + off);
        hb  = (h >= int'(i_hblk_start)) || (h < int'(i_hblk_end));
        vb  = (ln >= int'(i_vblk_start)) || (ln < int'(i_vblk_end));
        sa  = int'(i_hadj); if (sa >= 8) sa -= 16;
        sv  = int'(i_vadj); if (sv >= 8) sv -= 16;
        w   = '0;
        for (int i = 0; i < NW; i++)
            w[i] = (h >= int'(i_win_h0[i*HW +: HW])) && (h < int'(i_win_h1[i*HW +: HW])) &&
                   (ln >= int'(i_win_v0[i*VW +: VW])) && (ln < int'(i_win_v1[i*VW +: VW]));
        check("hcnt", 32'(o_hcnt), h);
        check("vcnt", 32'(o_vcnt), ln);
        check("field", 32'(o_field), fld);
        check("hsync_n", 32'(o_HSYNC_n), 32'(!hs));
        check("csync_n", 32'(o_CSYNC_n), 32'(!(hs ^ vs)));
        check("blk_n", 32'(o_BLK_n), 32'(!(hb || vb)));
        check("hadj", 32'(o_hadj_cnt), (h + sa + 512) % 512);
        check("vadj", 32'(o_vadj_cnt), (ln + sv + 512) % 512);
        check("line_tick", 32'(o_line_tick), 32'(h == 0));
        check("frame_tick", 32'(o_frame_tick), 32'(h == 0 && ln == 0));
        check("win", 32'(o_win), 32'(w));
    endtask

    task automatic step(input bit rand_en, input bit use_model);
        i_phiL_NCEN = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge phiA);
        #1;
        if (i_phiL_NCEN) k++;
        if (use_model) check_model();
    endtask

    task automatic do_reset();
        RST_async_n = 1'b0;
        i_phiL_NCEN = 1'b1;
        #1;
        k = 0;
        check_model();
        @(posedge phiA);
        #1;
        RST_async_n = 1'b1;
    endtask

    task automatic wait_pos(input int h, input int v, input int bound, input bit use_model,
                            input string tag);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            step(1'b0, use_model);
            if (int'(o_hcnt) == h && int'(o_vcnt) == v) found = 1'b1;
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic set_ntsc(input bit il);
        i_hlast = 9'd341; i_vlast = 9'd261; i_il = il;
        i_hsync_end = 9'd25; i_vsync_start = 9'd3; i_vsync_end = 9'd6;
        i_hblk_start = 9'd300; i_hblk_end = 9'd20;
        i_vblk_start = 9'd250; i_vblk_end = 9'd10;
        i_hadj = 4'b1000; i_vadj = 4'd7;
        i_win_h0 = {9'd100, 9'd40}; i_win_h1 = {9'd100, 9'd296};
        i_win_v0 = {9'd0, 9'd16};   i_win_v1 = {9'd300, 9'd228};
    endtask

    initial begin
        int last_tick, f1_max, seen_a, seen_b, L, vl;
        bit seen_w0, seen_adj;
        logic fields[$];

        set_ntsc(1'b0);
        #2;

        // NTSC free-run: line period, sync pins, adjust wrap, window corner.
        do_reset();
        last_tick = -1;
        seen_w0 = 1'b0;
        seen_adj = 1'b0;
        for (int c = 0; c < 17 * 342; c++) begin
            step(1'b0, 1'b1);
            if (o_line_tick) begin
                if (last_tick >= 0) check("line_period", 32'(k - last_tick), 342);
                last_tick = k;
            end
            if (o_vcnt == 0 && o_hcnt == 24) check("hsync_low_24", 32'(o_HSYNC_n), 0);
            if (o_vcnt == 0 && o_hcnt == 25) check("hsync_high_25", 32'(o_HSYNC_n), 1);
            if (o_vcnt == 4 && o_hcnt == 10) check("csync_l4_h10", 32'(o_CSYNC_n), 1);
            if (o_vcnt == 4 && o_hcnt == 100) check("csync_l4_h100", 32'(o_CSYNC_n), 0);
            if (o_vcnt == 0 && o_hcnt == 3) begin
                check("hadj_wrap", 32'(o_hadj_cnt), 507);
                seen_adj = 1'b1;
            end
            if (o_win[0] && !seen_w0) begin
                seen_w0 = 1'b1;
                check("win0_first_h", 32'(o_hcnt), 40);
                check("win0_first_v", 32'(o_vcnt), 16);
            end
        end
        check("win0_seen", 32'(seen_w0), 1);
        check("hadj_seen", 32'(seen_adj), 1);

        // Interlace on a short frame: field order, field-1 length, half-line vsync.
        set_ntsc(1'b1);
        i_vlast = 9'd9;
        do_reset();
        f1_max = -1;
        seen_a = 0;
        seen_b = 0;
        for (int c = 0; c < 21 * 342 + 400; c++) begin
            step(1'b0, 1'b1);
            if (o_frame_tick) fields.push_back(o_field);
            if (o_field && int'(o_vcnt) > f1_max) f1_max = int'(o_vcnt);
            if (o_field && o_vcnt == 3 && o_hcnt == 169) begin
                check("il_vs_before_half", 32'(o_CSYNC_n), 1);
                seen_a++;
            end
            if (o_field && o_vcnt == 3 && o_hcnt == 170) begin
                check("il_vs_at_half", 32'(o_CSYNC_n), 0);
                seen_b++;
            end
        end
        check("il_frame_ticks", 32'(fields.size()), 3);
        if (fields.size() >= 3) begin
            check("il_field_a", 32'(fields[0]), 0);
            check("il_field_b", 32'(fields[1]), 1);
            check("il_field_c", 32'(fields[2]), 0);
        end
        check("il_f1_lines", 32'(f1_max + 1), 11);
        check("il_seen_pre", 32'(seen_a), 1);
        check("il_seen_edge", 32'(seen_b), 1);

        // Vertical adjust wrap near the top of the counter range.
        set_ntsc(1'b0);
        i_hlast = 9'd3; i_vlast = 9'd511; i_hsync_end = 9'd1; i_hblk_start = 9'd3;
        i_hblk_end = 9'd0;
        do_reset();
        seen_adj = 1'b0;
        for (int c = 0; c < 3400 && !seen_adj; c++) begin
            step(1'b1, 1'b1);
            if (o_vcnt == 510) begin
                check("vadj_wrap", 32'(o_vadj_cnt), 5);
                seen_adj = 1'b1;
            end
        end
        check("vadj_seen", 32'(seen_adj), 1);

        // Randomized geometry with a random clock enable.
        for (int t = 0; t < 6; t++) begin
            L  = int'($urandom_range(8, 48));
            vl = int'($urandom_range(3, 12));
            i_hlast = 9'(L - 1); i_vlast = 9'(vl); i_il = 1'($urandom_range(0, 1));
            i_hsync_end = 9'($urandom_range(0, L));
            i_hblk_start = 9'($urandom_range(0, L + 2)); i_hblk_end = 9'($urandom_range(0, L));
            i_vsync_start = 9'($urandom_range(0, vl + 2)); i_vsync_end = 9'($urandom_range(0, vl + 3));
            i_vblk_start = 9'($urandom_range(0, vl + 2)); i_vblk_end = 9'($urandom_range(0, vl));
            i_hadj = 4'($urandom_range(0, 15)); i_vadj = 4'($urandom_range(0, 15));
            for (int i = 0; i < NW; i++) begin
                i_win_h0[i*HW +: HW] = 9'($urandom_range(0, L + 1));
                i_win_h1[i*HW +: HW] = 9'($urandom_range(0, L + 1));
                i_win_v0[i*VW +: VW] = 9'($urandom_range(0, vl + 3));
                i_win_v1[i*VW +: VW] = 9'($urandom_range(0, vl + 3));
            end
            do_reset();
            for (int c = 0; c < 2600; c++) step(1'b1, 1'b1);
        end

        // Lowering i_hlast below the running hcnt: count on through the wrap.
        set_ntsc(1'b0);
        i_hlast = 9'd40; i_vlast = 9'd20;
        do_reset();
        wait_pos(30, 0, 100, 1'b1, "lower_reach");
        i_hlast = 9'd10;
        for (int j = 0; j < 520; j++) begin
            step(1'b0, 1'b0);
            if (j <= 480) check("lower_climb", 32'(o_hcnt), 31 + j);
            else check("lower_resume", 32'(o_hcnt), (j - 481) % 11);
            if (j == 481) check("lower_vcnt_hold", 32'(o_vcnt), 0);
            if (j == 492) check("lower_vcnt_step", 32'(o_vcnt), 1);
        end

        // Reset asserted mid-line takes effect before the next edge.
        set_ntsc(1'b0);
        do_reset();
        wait_pos(150, 0, 400, 1'b1, "midline_reach");
        #2;
        RST_async_n = 1'b0;
        #1;
        k = 0;
        check_model();
        @(posedge phiA);
        #1;
        RST_async_n = 1'b1;
        for (int c = 0; c < 50; c++) step(1'b0, 1'b1);

`ifdef IKA9958_ST_EXTLOCK_EN
        // External locks.
        set_ntsc(1'b0);
        i_vlast = 9'd9;
        do_reset();
        wait_pos(200, 6, 4000, 1'b0, "hrst_reach6");
        i_HRST_n = 1'b0;
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check("hrst_pre", 32'(o_hcnt), 203);
        step(1'b0, 1'b0);
        check("hrst_zero", 32'(o_hcnt), 0);
        check("hrst_vcnt", 32'(o_vcnt), 6);
        i_HRST_n = 1'b1;
        wait_pos(200, 7, 1000, 1'b0, "hrst_reach7");
        i_HRST_n = 1'b0;
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
        check("hrst_ignored", 32'(o_hcnt), 204);
        i_HRST_n = 1'b1;
        wait_pos(100, 3, 4000, 1'b0, "vrst_reach");
        i_VRST_n = 1'b0;
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
        check("vrst_pre", 32'(o_vcnt), 3);
        step(1'b0, 1'b0);
        check("vrst_vcnt", 32'(o_vcnt), 0);
        check("vrst_field", 32'(o_field), 0);
        i_VRST_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
